// File: rtl/sha256_wntz_chain.sv
// Winternitz hash-chain sequencer: value = H(prefix || j || value) for j = start_j..stop_j,
// one single-block SHA-256 per step, issued to an external sha256_core.
module sha256_wntz_chain #(
    parameter int PREFIX_BYTES = 22
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      zeroize,
    input  logic                      start,
    input  logic                      abort,
    input  logic [3:0]                w,
    input  logic                      n_mode,
    input  logic [8*PREFIX_BYTES-1:0] prefix,
    input  logic [255:0]              seed,
    input  logic [7:0]                start_j,
    input  logic [7:0]                stop_j,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [255:0]              result,
    output logic                      result_valid,
    output logic [8:0]                step_cnt,
    output logic                      core_zeroize,
    output logic                      core_init,
    output logic                      core_mode,
    output logic [511:0]              core_block,
    input  logic                      core_ready,
    input  logic [255:0]              core_digest,
    input  logic                      core_digest_valid
);

    localparam logic [63:0] LEN_N32 = 64'((PREFIX_BYTES + 33) * 8);
    localparam logic [63:0] LEN_N24 = 64'((PREFIX_BYTES + 25) * 8);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic [8*PREFIX_BYTES-1:0] prefix_reg;
    logic [255:0]              chain_reg;
    logic [7:0]                j_reg, stop_reg;
    logic                      n_reg;
    logic                      dv_q;
    logic                      dv_rise;
    logic                      start_ok;

    // SHA-192 truncation keeps only the upper 24 bytes of a value.
    function automatic logic [255:0] mask_n(input logic [255:0] v, input logic n32);
        return n32 ? v : {v[255:64], 64'h0};
    endfunction

    function automatic logic start_legal(input logic [3:0] wp, input logic [7:0] sj,
                                         input logic [7:0] ej);
        logic [7:0] limit;
        logic       w_ok;
        w_ok  = 1'b1;
        limit = 8'd0;
        case (wp)
            4'd1:    limit = 8'd0;
            4'd2:    limit = 8'd2;
            4'd4:    limit = 8'd14;
            4'd8:    limit = 8'd254;
            default: w_ok  = 1'b0;
        endcase
        return w_ok && (sj <= ej) && (ej <= limit);
    endfunction

    // Chain value is already masked, so for n=24 its low 8 bytes are zero before 0x80 lands.
    function automatic logic [511:0] build_block(input logic [8*PREFIX_BYTES-1:0] pfx,
                                                 input logic [7:0] j, input logic [255:0] v,
                                                 input logic n32);
        logic [511:0] b;
        b = '0;
        b[511 -: 8*PREFIX_BYTES]           = pfx;
        b[511-8*PREFIX_BYTES -: 8]         = j;
        b[511-8*(PREFIX_BYTES+1) -: 256]   = v;
        if (n32) begin
            b[511-8*(PREFIX_BYTES+33) -: 8] = 8'h80;
            b[63:0]                         = LEN_N32;
        end else begin
            b[511-8*(PREFIX_BYTES+25) -: 8] = 8'h80;
            b[63:0]                         = LEN_N24;
        end
        return b;
    endfunction

    assign dv_rise      = core_digest_valid & ~dv_q;
    assign start_ok     = start_legal(w, start_j, stop_j);
    assign busy         = (state != S_IDLE);
    assign core_zeroize = zeroize;
    assign core_mode    = 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && start_ok) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (abort)           state_nxt = S_IDLE;
                else if (core_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (abort)        state_nxt = S_DRAIN;
                else if (dv_rise) state_nxt = (j_reg == stop_reg) ? S_DONE : S_ISSUE;
            end
            S_DRAIN: if (dv_rise) state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            state        <= S_IDLE;
            prefix_reg   <= '0;
            chain_reg    <= '0;
            j_reg        <= '0;
            stop_reg     <= '0;
            n_reg        <= 1'b0;
            dv_q         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            step_cnt     <= '0;
            core_init    <= 1'b0;
            core_block   <= '0;
        end else begin
            state     <= state_nxt;
            dv_q      <= core_digest_valid;
            done      <= 1'b0;
            error     <= 1'b0;
            core_init <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !start_ok) begin
                        error <= 1'b1;
                    end else if (start) begin
                        prefix_reg   <= prefix;
                        chain_reg    <= mask_n(seed, n_mode);
                        n_reg        <= n_mode;
                        j_reg        <= start_j;
                        stop_reg     <= stop_j;
                        step_cnt     <= '0;
                        result_valid <= 1'b0;
                    end
                end
                // Block is registered together with init so it is stable for the whole hash.
                S_ISSUE: begin
                    if (!abort && core_ready) begin
                        core_init  <= 1'b1;
                        core_block <= build_block(prefix_reg, j_reg, chain_reg, n_reg);
                    end
                end
                S_WAIT: begin
                    if (!abort && dv_rise) begin
                        chain_reg <= mask_n(core_digest, n_reg);
                        step_cnt  <= step_cnt + 9'd1;
                        if (j_reg != stop_reg) j_reg <= j_reg + 8'd1;
                    end
                end
                S_DONE: begin
                    done         <= 1'b1;
                    result       <= chain_reg;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
